// File: rtl/mac_pe_acc.sv
// Systolic-array MAC processing element: forwards operands east/south and
// accumulates signed products over windows of K_DEPTH valid samples.
module mac_pe_acc #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 20,
    parameter int K_DEPTH  = 4,
    parameter int SATURATE = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_valid,
    input  logic signed [DATA_W-1:0]       i_a,
    input  logic signed [DATA_W-1:0]       i_b,
    input  logic                           i_clear,
    output logic signed [DATA_W-1:0]       o_x,
    output logic signed [DATA_W-1:0]       o_y,
    output logic                           o_valid,
    output logic signed [ACC_W-1:0]        o_out,
    output logic                           o_out_valid,
    output logic [$clog2(K_DEPTH+1)-1:0]   o_transaction_cnt,
    output logic                           o_sat
);

    localparam int CNT_W = $clog2(K_DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K_DEPTH - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                    state_reg, state_next;
    logic signed [ACC_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]          cnt_reg, cnt_next;
    logic signed [ACC_W-1:0]   out_reg, out_next;
    logic                      out_valid_reg, out_valid_next;
    logic                      sat_reg, sat_next;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W:0]      prod_ext;
    logic signed [ACC_W:0]      sum;
    logic signed [ACC_W-1:0]    res;
    logic                       ovf;

    // Both addends fit in ACC_W bits, so one guard bit makes the sum exact.
    assign prod     = i_a * i_b;
    assign prod_ext = (ACC_W+1)'(prod);
    assign sum      = (ACC_W+1)'(acc_reg) + prod_ext;
    assign ovf      = sum[ACC_W] ^ sum[ACC_W-1];

    generate
        if (SATURATE != 0) begin : g_sat
            always_comb begin
                res = sum[ACC_W-1:0];
                if (ovf) begin
                    res = sum[ACC_W] ? ACC_MIN : ACC_MAX;
                end
            end
        end else begin : g_wrap
            assign res = sum[ACC_W-1:0];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        out_next       = out_reg;
        out_valid_next = 1'b0;
        sat_next       = sat_reg;

        if (i_clear) begin
            sat_next = 1'b0;
            if (i_valid && (K_DEPTH == 1)) begin
                out_next       = prod_ext[ACC_W-1:0];
                out_valid_next = 1'b1;
                acc_next       = '0;
                cnt_next       = '0;
                state_next     = IDLE;
            end else if (i_valid) begin
                // The clearing sample opens a fresh window as its first sample.
                acc_next   = prod_ext[ACC_W-1:0];
                cnt_next   = CNT_W'(1);
                state_next = ACCUM;
            end else begin
                acc_next   = '0;
                cnt_next   = '0;
                state_next = IDLE;
            end
        end else if (i_valid) begin
            sat_next = sat_reg | ovf;
            if (cnt_reg == LAST_CNT) begin
                out_next       = res;
                out_valid_next = 1'b1;
                acc_next       = '0;
                cnt_next       = '0;
                state_next     = IDLE;
            end else begin
                acc_next   = res;
                cnt_next   = cnt_reg + CNT_W'(1);
                state_next = ACCUM;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            sat_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            sat_reg       <= sat_next;
        end
    end

    // Operand forwarding ignores i_clear so neighbours see an unbroken stream.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_x     <= '0;
            o_y     <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_x <= i_a;
                o_y <= i_b;
            end
        end
    end

    assign o_out             = out_reg;
    assign o_out_valid       = out_valid_reg;
    assign o_transaction_cnt = cnt_reg;
    assign o_sat             = sat_reg;

endmodule

// File: tb/tb_mac_pe_acc.sv
// Directed bench for mac_pe_acc: default, 16-bit saturating, 16-bit wrapping
// and single-sample-window instances share one stimulus stream.
module tb_mac_pe_acc;

    logic clk = 1'b0;
    logic rst_n;
    logic valid;
    logic signed [7:0] ia, ib;
    logic clear;

    always #5 clk = ~clk;

    logic signed [7:0]  x_d, y_d, x_s, y_s, x_w, y_w, x_k, y_k;
    logic               v_d, v_s, v_w, v_k;
    logic signed [19:0] out_d, out_k;
    logic signed [15:0] out_s, out_w;
    logic               ov_d, ov_s, ov_w, ov_k;
    logic [2:0]         cnt_d, cnt_s, cnt_w;
    logic [0:0]         cnt_k;
    logic               sat_d, sat_s, sat_w, sat_k;

    mac_pe_acc u_def (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_a(ia), .i_b(ib), .i_clear(clear),
        .o_x(x_d), .o_y(y_d), .o_valid(v_d), .o_out(out_d), .o_out_valid(ov_d),
        .o_transaction_cnt(cnt_d), .o_sat(sat_d)
    );

    mac_pe_acc #(.ACC_W(16), .SATURATE(1)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_a(ia), .i_b(ib), .i_clear(clear),
        .o_x(x_s), .o_y(y_s), .o_valid(v_s), .o_out(out_s), .o_out_valid(ov_s),
        .o_transaction_cnt(cnt_s), .o_sat(sat_s)
    );

    mac_pe_acc #(.ACC_W(16), .SATURATE(0)) u_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_a(ia), .i_b(ib), .i_clear(clear),
        .o_x(x_w), .o_y(y_w), .o_valid(v_w), .o_out(out_w), .o_out_valid(ov_w),
        .o_transaction_cnt(cnt_w), .o_sat(sat_w)
    );

    mac_pe_acc #(.K_DEPTH(1)) u_k1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_a(ia), .i_b(ib), .i_clear(clear),
        .o_x(x_k), .o_y(y_k), .o_valid(v_k), .o_out(out_k), .o_out_valid(ov_k),
        .o_transaction_cnt(cnt_k), .o_sat(sat_k)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Apply one cycle of input, then sample just after the capturing edge.
    task automatic drive(input logic v, input int a, input int b, input logic clr);
        valid = v;
        ia    = 8'(a);
        ib    = 8'(b);
        clear = clr;
        @(posedge clk);
        #1;
        valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        drive(1'b0, 0, 0, 1'b0);
        rst_n = 1'b1;
    endtask

    int ta[4] = '{3, -2, 7, -1};
    int tb[4] = '{4, 5, 7, -1};

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        clear = 1'b0;
        ia    = '0;
        ib    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", out_d, 0);
        check("rst_out_valid", ov_d, 0);
        check("rst_cnt", cnt_d, 0);
        check("rst_sat", sat_d, 0);
        check("rst_x", x_d, 0);
        check("rst_valid", v_d, 0);
        rst_n = 1'b1;

        // Back-to-back window: 12 - 10 + 49 + 1 = 52
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ta[i], tb[i], 1'b0);
            check("t1_cnt", cnt_d, (i + 1) % 4);
            check("t1_pulse", ov_d, (i == 3) ? 1 : 0);
            check("t1_x", x_d, ta[i]);
            check("t1_y", y_d, tb[i]);
        end
        check("t1_out", out_d, 52);
        check("t1_sat", sat_d, 0);
        drive(1'b0, 0, 0, 1'b0);
        check("t1_pulse_end", ov_d, 0);
        check("t1_out_hold", out_d, 52);
        check("t1_valid_low", v_d, 0);

        // Same window with 2-cycle gaps, then 4x(1,1) immediately after
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ta[i], tb[i], 1'b0);
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    drive(1'b0, 99, -77, 1'b0);
                    check("t2_x_hold", x_d, ta[i]);
                    check("t2_y_hold", y_d, tb[i]);
                    check("t2_gap_pulse", ov_d, 0);
                    check("t2_gap_cnt", cnt_d, i + 1);
                end
            end
        end
        check("t2_pulse", ov_d, 1);
        check("t2_out", out_d, 52);
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 1, 1, 1'b0);
            check("t2b_pulse", ov_d, (j == 3) ? 1 : 0);
        end
        check("t2b_out", out_d, 4);

        // 16-bit saturate and wrap: 4 x 16384
        pulse_reset();
        drive(1'b1, -128, -128, 1'b0);
        check("t3_sat_after1", sat_s, 0);
        check("t3_k1_out", out_k, 16384);
        check("t3_k1_pulse", ov_k, 1);
        check("t3_k1_cnt", cnt_k, 0);
        drive(1'b1, -128, -128, 1'b0);
        check("t3_sat_after2", sat_s, 1);
        check("t3_wrap_sat_after2", sat_w, 1);
        drive(1'b1, -128, -128, 1'b0);
        drive(1'b1, -128, -128, 1'b0);
        check("t3_sat_pulse", ov_s, 1);
        check("t3_sat_out", out_s, 32767);
        check("t3_sat_flag", sat_s, 1);
        check("t3_wrap_out", out_w, 0);
        check("t3_wrap_flag", sat_w, 1);
        drive(1'b0, 0, 0, 1'b1);
        check("t3_clear_sat", sat_s, 0);
        check("t3_clear_out_hold", out_s, 32767);
        check("t3_clear_cnt", cnt_s, 0);
        // 4 x -16256: clamps on the 3rd sample
        drive(1'b1, 127, -128, 1'b0);
        drive(1'b1, 127, -128, 1'b0);
        check("t3n_sat_after2", sat_s, 0);
        drive(1'b1, 127, -128, 1'b0);
        check("t3n_sat_after3", sat_s, 1);
        drive(1'b1, 127, -128, 1'b0);
        check("t3n_out", out_s, -32768);
        check("t3n_pulse", ov_s, 1);
        check("t3n_sat", sat_s, 1);

        // Clear without valid after 2 samples, then 4x(2,3) = 24
        pulse_reset();
        drive(1'b1, 1, 1, 1'b0);
        drive(1'b1, 1, 1, 1'b0);
        drive(1'b0, 0, 0, 1'b1);
        check("t4_clear_cnt", cnt_d, 0);
        check("t4_clear_pulse", ov_d, 0);
        for (int j = 0; j < 4; j++) drive(1'b1, 2, 3, 1'b0);
        check("t4_out", out_d, 24);
        check("t4_pulse", ov_d, 1);
        // Clear together with the 4th sample: restart with 25, then +3 = 28
        for (int j = 0; j < 3; j++) drive(1'b1, 1, 1, 1'b0);
        drive(1'b1, 5, 5, 1'b1);
        check("t4c_pulse", ov_d, 0);
        check("t4c_cnt", cnt_d, 1);
        check("t4c_out_hold", out_d, 24);
        check("t4c_k1_out", out_k, 25);
        check("t4c_k1_pulse", ov_k, 1);
        for (int j = 0; j < 3; j++) drive(1'b1, 1, 1, 1'b0);
        check("t4c_out", out_d, 28);
        check("t4c_pulse_end", ov_d, 1);

        // Reset mid-window, then a fresh 4x(2,2) = 16
        for (int j = 0; j < 3; j++) drive(1'b1, 2, 2, 1'b0);
        check("t5_cnt_pre", cnt_d, 3);
        pulse_reset();
        check("t5_out", out_d, 0);
        check("t5_pulse", ov_d, 0);
        check("t5_cnt", cnt_d, 0);
        check("t5_x", x_d, 0);
        check("t5_y", y_d, 0);
        check("t5_sat", sat_d, 0);
        for (int j = 0; j < 4; j++) drive(1'b1, 2, 2, 1'b0);
        check("t5_fresh_out", out_d, 16);
        check("t5_fresh_pulse", ov_d, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
